pqvalue_seq: RTL
================

PQVALUE_SEQ -- requirements
Module: pqvalue_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, element address width.
REQ-002 The block SHALL have parameter DATA_W, default 23, coefficient width.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk_i  in  1  clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  command strobe; sampled only in IDLE.
REQ-007 op_i  in  2  01 mod_add, 10 mod_sub, 11 mod_mul, 00 illegal.
REQ-008 red_i  in  1  0 Dilithium (q=8380417), 1 Kyber (q=3329).
REQ-009 src_a_i, src_b_i, dst_i  in  ADDR_W  base addresses.
REQ-010 len_i  in  ADDR_W  element count; 0 is legal.
REQ-011 busy_o  out  1  high from the cycle after start is accepted until done_o.
REQ-012 done_o  out  1  one-cycle completion pulse.
REQ-013 err_o  out  1  one-cycle pulse on illegal op.
REQ-014 mem_re_o  out  1  read strobe; both read ports.
REQ-015 mem_ra_addr_o, mem_rb_addr_o  out  ADDR_W  read addresses.
REQ-016 mem_ra_data_i, mem_rb_data_i  in  DATA_W  read data, valid exactly 1 cycle after mem_re_o.
REQ-017 alu_a_o, alu_b_o  out  DATA_W  ALU operands.
REQ-018 alu_sel_op_o  out  2  ALU operation select.
REQ-019 alu_sel_red_o  out  1  ALU reduction select.
REQ-020 alu_res_i  in  DATA_W  combinational ALU result.
REQ-021 mem_we_o  out  1  write strobe.
REQ-022 mem_wa_o  out  ADDR_W  write address.
REQ-023 mem_wd_o  out  DATA_W  write data.

Function
REQ-024 FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-025 IDLE + start_i + legal op + len_i>0 -> RUN; op_i, red_i, bases and len SHALL be latched on that edge.
REQ-026 IDLE + start_i + op_i=00 -> err_o pulse next cycle; stay IDLE; no memory access.
REQ-027 IDLE + start_i + len_i=0 -> DONE; done_o pulses next cycle; no memory access.
REQ-028 RUN: one read per cycle, index i=0..len-1; mem_ra_addr_o=src_a+i, mem_rb_addr_o=src_b+i, mem_re_o=1.
REQ-029 Stage 2 (cycle after read): alu_a_o/alu_b_o SHALL equal read data; alu_res_i captured into write register.
REQ-030 Stage 3: mem_we_o=1, mem_wa_o=dst+i, mem_wd_o=captured result; read-to-write latency 2 cycles, throughput 1 element/cycle.
REQ-031 After last read, RUN -> DRAIN; DRAIN -> DONE when final write issues; DONE -> IDLE after one cycle with done_o=1.
REQ-032 For len=N, first read SHALL occur in the cycle after acceptance, last write N+2 cycles after acceptance, done_o one cycle later.
REQ-033 alu_sel_op_o/alu_sel_red_o SHALL hold latched values while busy and 0 in IDLE.
REQ-034 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-035 start_i while busy SHALL be ignored; no queuing.
REQ-036 dst==src (in place) SHALL be correct, since read of i precedes write of i; other overlaps are undefined.

Reset
REQ-037 On rst_ni low, FSM -> IDLE and every output SHALL be 0, including during an operation; in-flight writes SHALL be dropped.
REQ-038 After release, the block SHALL accept start_i on the first clock edge.

Structure
REQ-039 Package pqvalue_pkg SHALL hold the op encoding enum, the q constants (8380417, 3329) and the FSM state enum.
REQ-040 The ALU SHALL stay outside this block; no sub-module is required.

Verification
REQ-041 Kyber add, a=3000, b=500, len=1 -> one write of 171 at dst, done_o 4 cycles after acceptance.
REQ-042 Kyber sub, a=5, b=10 -> write 3324; Dilithium add, a=8380416, b=2 -> write 1.
REQ-043 len=4, src_a=0xFE (wraps) -> reads at FE, FF, 00, 01; four back-to-back writes, done_o at cycle 7.
REQ-044 op_i=00 -> err_o pulse, no mem_re_o/mem_we_o; len_i=0 -> done_o pulse, no memory access.
REQ-045 rst_ni asserted mid-RUN with len=8 -> all outputs 0 immediately, no further writes; new start_i after release executes normally.

Source files
------------

// File: rtl/pqvalue_pkg.sv
// Shared types and constants for the pqvalue element-wise sequencer.
// Holds the ALU op encoding, the two NTT-friendly moduli and the FSM states.
package pqvalue_pkg;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_ADD     = 2'b01,
    OP_SUB     = 2'b10,
    OP_MUL     = 2'b11
  } op_e;

  localparam int unsigned Q_DILITHIUM = 32'd8380417;
  localparam int unsigned Q_KYBER     = 32'd3329;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/pqvalue_seq.sv
// Streams len elements through an external modular ALU: read a/b, compute, write dst.
// Three-stage pipeline (read, operand/capture, write) at one element per cycle.
module pqvalue_seq
  import pqvalue_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 23
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic              red_i,
  input  logic [ADDR_W-1:0] src_a_i,
  input  logic [ADDR_W-1:0] src_b_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_ra_addr_o,
  output logic [ADDR_W-1:0] mem_rb_addr_o,
  input  logic [DATA_W-1:0] mem_ra_data_i,
  input  logic [DATA_W-1:0] mem_rb_data_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [1:0]        alu_sel_op_o,
  output logic              alu_sel_red_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_wa_o,
  output logic [DATA_W-1:0] mem_wd_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  op_e               op_q;
  logic              red_q;
  logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q, len_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic              s2_valid_q;
  logic [ADDR_W-1:0] s2_idx_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              err_q;

  logic accept;
  logic illegal;
  logic rd_en;

  assign accept  = (state_q == S_IDLE) && start_i;
  assign illegal = (op_i == OP_ILLEGAL);
  assign rd_en   = (state_q == S_RUN);

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !illegal) state_d = (len_i == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (rd_idx_q == len_q - ADDR_ONE) state_d = S_DRAIN;
      end
      // The final write is in flight once stage 2 is empty and stage 3 is full.
      S_DRAIN: begin
        if (wr_valid_q && !s2_valid_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ILLEGAL;
      red_q      <= 1'b0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rd_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && illegal;

      if (accept && !illegal) begin
        op_q    <= op_e'(op_i);
        red_q   <= red_i;
        src_a_q <= src_a_i;
        src_b_q <= src_b_i;
        dst_q   <= dst_i;
        len_q   <= len_i;
      end

      if (accept)     rd_idx_q <= '0;
      else if (rd_en) rd_idx_q <= rd_idx_q + ADDR_ONE;

      s2_valid_q <= rd_en;
      s2_idx_q   <= rd_idx_q;

      wr_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        wr_addr_q <= dst_q + s2_idx_q;
        wr_data_q <= alu_res_i;
      end
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;

  assign mem_re_o      = rd_en;
  assign mem_ra_addr_o = rd_en ? src_a_q + rd_idx_q : '0;
  assign mem_rb_addr_o = rd_en ? src_b_q + rd_idx_q : '0;

  // Operands are the raw read data; gated so they read zero outside stage 2.
  assign alu_a_o       = s2_valid_q ? mem_ra_data_i : '0;
  assign alu_b_o       = s2_valid_q ? mem_rb_data_i : '0;
  assign alu_sel_op_o  = busy_o ? op_q : 2'b00;
  assign alu_sel_red_o = busy_o & red_q;

  assign mem_we_o      = wr_valid_q;
  assign mem_wa_o      = wr_valid_q ? wr_addr_q : '0;
  assign mem_wd_o      = wr_valid_q ? wr_data_q : '0;

endmodule
